avr_serial_tx: RTL and testbench

Byte-wide UART transmitter that drives the FPGA-to-AVR serial line (`avr_rx` at the top level) on the Mojo board. Sits directly downstream of the top module's `avr_rx` output and replaces its tie-off. Also gates traffic on AVR readiness, derived from `cclk`, and on the AVR's `avr_rx_busy` flow-control pin. Fabric logic hands it one byte at a time through a valid/busy handshake.

---
 rtl/avr_if_pkg.sv | 41 ++++
 rtl/cclk_detector.sv | 74 +++++++
 rtl/avr_serial_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_avr_serial_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_if_pkg.sv
// -----------------------------------------------------------------------------
// avr_if_pkg
//
// Shared definitions for the FPGA-to-AVR interface blocks on the Mojo board
// (serial TX today, serial RX and SPI later).
//
// Contents:
//   - DEF_CLK_RATE / DEF_BAUD / DEF_CCLK_HOLD : default block parameters
//   - avr_tx_state_e                          : serial FSM state encoding
//   - clk_per_bit()                           : clocks per serial bit time
//   - cnt_width()                             : counter width for 0..n-1,
//                                               never narrower than 1 bit
// -----------------------------------------------------------------------------
package avr_if_pkg;

  localparam int unsigned DEF_CLK_RATE  = 50_000_000;
  localparam int unsigned DEF_BAUD      = 500_000;
  localparam int unsigned DEF_CCLK_HOLD = 512;

  // PARITY is always encoded so every AVR block agrees on the state values,
  // even in builds where the transmitter never enters it.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } avr_tx_state_e;

  // CLK_RATE must be an integer multiple of BAUD with a ratio of at least 4.
  function automatic int unsigned clk_per_bit(input int unsigned clk_rate,
                                              input int unsigned baud);
    return clk_rate / baud;
  endfunction

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cclk_detector.sv
// -----------------------------------------------------------------------------
// cclk_detector
//
// Decides when the AVR is up. The AVR drives cclk high once it has finished
// configuring the FPGA. We wait until the synchronized level has stayed high
// for CCLK_HOLD consecutive cycles before asserting ready. Any low sample
// drops ready and restarts the hold time.
//
// Parameters:
//   CCLK_HOLD : consecutive synchronized-high cclk cycles before ready
//
// Ports:
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset
//   cclk  in  : AVR configuration clock, asynchronous to clk
//   ready out : AVR link usable (registered)
//
// Latency: cclk rising -> ready after 2 + CCLK_HOLD cycles.
//          cclk falling -> ready low after 3 cycles.
// -----------------------------------------------------------------------------
module cclk_detector
  import avr_if_pkg::*;
#(
  parameter int unsigned CCLK_HOLD = DEF_CCLK_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cclk,
  output logic ready
);

  localparam int unsigned    CW      = cnt_width(CCLK_HOLD);
  localparam logic [CW-1:0]  CNT_MAX = CW'(CCLK_HOLD - 1);

  logic [1:0]    r_cclk_sync;
  logic          w_cclk_s;
  logic [CW-1:0] r_hold_cnt;
  logic          r_ready;

  // Two-flop synchronizer. Bit 0 may go metastable. Only bit 1 is used.
  // NOTE: synchronizer flops are reset to a known 0 so ready cannot glitch
  // high straight out of reset. They are ordinary flops, not a memory array,
  // so resetting them costs nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cclk_sync <= 2'b00;
    end else begin
      // NOTE: all clocked state uses non-blocking assignment, so every flop
      // samples the pre-edge value of its neighbours.
      r_cclk_sync <= {r_cclk_sync[0], cclk};
    end
  end

  assign w_cclk_s = r_cclk_sync[1];

  // The hold counter saturates at CCLK_HOLD-1. ready is registered from the
  // counter, so a low cclk_s clears both on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      if (!w_cclk_s) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != CNT_MAX) begin
        r_hold_cnt <= r_hold_cnt + CW'(1);
      end
      r_ready <= w_cclk_s && (r_hold_cnt == CNT_MAX);
    end
  end

  assign ready = r_ready;

endmodule

// File: rtl/avr_serial_tx.sv
// -----------------------------------------------------------------------------
// avr_serial_tx
//
// Byte-wide UART transmitter that drives the FPGA-to-AVR serial line on the
// Mojo board. Frames are sent LSB first with an idle-high line: 8N1 by
// default, or 8E1 when AVR_SERIAL_TX_PARITY_EN is defined. Traffic is gated
// on AVR readiness (derived from cclk) and on the AVR's avr_rx_busy
// flow-control pin.
//
// Compile-time option:
//   AVR_SERIAL_TX_PARITY_EN : insert an even-parity bit after data bit 7
//                             (frame = 11 bit times instead of 10)
//
// Parameters:
//   CLK_RATE  : clk frequency in Hz
//   BAUD      : line rate; CLK_RATE/BAUD must be an integer >= 4
//   CCLK_HOLD : synchronized-high cclk cycles required before ready
//
// Ports:
//   clk         in     : system clock
//   rst_n       in     : asynchronous active-low reset
//   cclk        in     : AVR configuration clock (asynchronous)
//   avr_rx_busy in     : AVR cannot accept bytes (asynchronous)
//   data        in [8] : byte to send, sampled only on acceptance
//   new_data    in     : single-cycle send request
//   busy        out    : new_data is not accepted this cycle
//   ready       out    : AVR is up and the link is usable
//   tx          out    : serial line to the AVR
//
// Handshake: new_data while busy=0 is accepted. A request while busy=1 is
// dropped. Acceptance on cycle N puts the start bit on tx and raises busy
// from N+1. busy drops on the cycle after the last stop-bit cycle, so a
// request on that cycle starts the next frame with no idle bit time.
// -----------------------------------------------------------------------------
module avr_serial_tx
  import avr_if_pkg::*;
#(
  parameter int unsigned CLK_RATE  = DEF_CLK_RATE,
  parameter int unsigned BAUD      = DEF_BAUD,
  parameter int unsigned CCLK_HOLD = DEF_CCLK_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cclk,
  input  logic       avr_rx_busy,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned   CLK_PER_BIT = clk_per_bit(CLK_RATE, BAUD);
  localparam int unsigned   BW          = cnt_width(CLK_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX    = BW'(CLK_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // AVR readiness and flow control
  // ---------------------------------------------------------------------------
  logic       w_ready;
  logic [1:0] r_abusy_sync;
  logic       w_abusy_s;

  cclk_detector #(
    .CCLK_HOLD (CCLK_HOLD)
  ) u_cclk_detector (
    .clk   (clk),
    .rst_n (rst_n),
    .cclk  (cclk),
    .ready (w_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abusy_sync <= 2'b00;
    end else begin
      r_abusy_sync <= {r_abusy_sync[0], avr_rx_busy};
    end
  end

  assign w_abusy_s = r_abusy_sync[1];

  // ---------------------------------------------------------------------------
  // Transmit FSM and datapath
  // ---------------------------------------------------------------------------
  avr_tx_state_e r_state;
  avr_tx_state_e w_state_next;
  logic [BW-1:0] r_baud_cnt;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_tx;
  logic          w_tx_next;
  logic          r_busy;
  logic          w_busy_next;
  logic          w_accept;
  logic          w_bit_end;

  // r_busy is low only in IDLE, so acceptance always starts from IDLE.
  assign w_accept  = new_data && !r_busy;
  assign w_bit_end = (r_baud_cnt == BAUD_MAX);

  // State, counters and the latched byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_next;
      r_bit_idx  <= w_bit_next;
      r_shift    <= w_shift_next;
    end
  end

  // Next-state logic. The baud counter free-runs inside a frame and is
  // returned to 0 at every bit boundary and throughout IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_next = r_state;
    w_baud_next  = r_baud_cnt + BW'(1);
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;

    unique case (r_state)
      ST_IDLE: begin
        w_baud_next = '0;
        w_bit_next  = 3'd0;
        if (w_accept) begin
          w_shift_next = data;
          w_state_next = ST_START;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          w_bit_next  = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef AVR_SERIAL_TX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end
        end
      end

`ifdef AVR_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_baud_next  = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // tx and busy are registered from the next state, so they change on the
  // same edge as the FSM and leave the chip glitch-free. Mid-frame loss of
  // ready or a rising avr_rx_busy only holds busy high. The frame in flight
  // always runs to its stop bit.
  always_comb begin
    w_tx_next = 1'b1;
    unique case (w_state_next)
      ST_IDLE:   w_tx_next = 1'b1;
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[w_bit_next];
`ifdef AVR_SERIAL_TX_PARITY_EN
      // Even parity: the parity bit makes the total count of ones even.
      ST_PARITY: w_tx_next = ^w_shift_next;
`endif
      ST_STOP:   w_tx_next = 1'b1;
      default:   w_tx_next = 1'b1;
    endcase

    w_busy_next = (w_state_next != ST_IDLE) || w_abusy_s || !w_ready;
  end

  // tx resets high so an abandoned frame returns the line to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b1;
    end else begin
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
    end
  end

  assign tx    = r_tx;
  assign busy  = r_busy;
  assign ready = w_ready;

endmodule

// File: tb/tb_avr_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_avr_serial_tx
//
// Directed bench for avr_serial_tx at default parameters (100 clocks/bit,
// 512-cycle cclk hold). A table of bytes with hand-computed line patterns is
// sent back-to-back. Hand-written sequences then cover reset-release timing,
// avr_rx_busy and cclk events during a frame, and reset in the middle of a
// frame. Define AVR_SERIAL_TX_PARITY_EN for both bench and RTL to exercise
// the 8E1 build.
//
// Cycle convention: inputs are driven and outputs sampled on the falling
// edge. Cycle N is the cycle during which new_data=1 and busy=0 are both
// present. The first sample after the next rising edge is cycle N+1.
// -----------------------------------------------------------------------------
module tb_avr_serial_tx;

  localparam int CPB  = 100;
  localparam int HOLD = 512;
`ifdef AVR_SERIAL_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NBITS  = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NBITS  = 10;
`endif

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       cclk        = 1'b0;
  logic       avr_rx_busy = 1'b0;
  logic [7:0] data        = 8'h00;
  logic       new_data    = 1'b0;
  logic       busy;
  logic       ready;
  logic       tx;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  // The frame field lists the line level for each bit time in send order:
  // bit 0 is the start bit, bits 1..8 are the data LSB first, and bit 9 is
  // the stop bit. par is the even-parity bit, used only in the parity build.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  avr_serial_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cclk        (cclk),
    .avr_rx_busy (avr_rx_busy),
    .data        (data),
    .new_data    (new_data),
    .busy        (busy),
    .ready       (ready),
    .tx          (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called on the falling edge of cycle N. It pulses new_data, then walks
  // the whole frame cycle by cycle and ends on cycle N+1+NBITS*CPB.
  task automatic send_frame(input logic [7:0] b, input logic [9:0] frm,
                            input logic par, input logic exp_busy_after,
                            input string tag);
    int   bad_tx;
    int   bad_busy;
    logic e;
    check($sformatf("%s busy at accept", tag), busy, 1'b0);
    data     = b;
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
    data     = ~b;  // must not disturb the frame in flight
    bad_busy = 0;
    for (int bt = 0; bt < NBITS; bt++) begin
      if (bt == 0)                 e = frm[0];
      else if (bt <= 8)            e = frm[bt];
      else if (PAR_EN && bt == 9)  e = par;
      else                         e = frm[9];
      bad_tx = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx !== e)       bad_tx++;
        if (busy !== 1'b1)  bad_busy++;
        tick();
      end
      check($sformatf("%s bit%0d tx wrong cycles", tag, bt), bad_tx, 0);
    end
    check($sformatf("%s busy low cycles in frame", tag), bad_busy, 0);
    check($sformatf("%s tx after frame", tag), tx, 1'b1);
    check($sformatf("%s busy after frame", tag), busy, exp_busy_after);
  endtask

  initial begin
    int first_ready;
    int first_free;
    int bad;

    vecs[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
    vecs[3] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
    vecs[4] = '{8'h80, 10'b1_1000_0000_0, 1'b1};
    vecs[5] = '{8'h3C, 10'b1_0011_1100_0, 1'b0};

    // ---------------- reset state and ready timing ----------------
    rst_n = 1'b0;
    cclk  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", tx, 1'b1);
    check("reset ready", ready, 1'b0);
    check("reset busy", busy, 1'b1);

    rst_n       = 1'b1;
    first_ready = 0;
    first_free  = 0;
    bad         = 0;
    for (int k = 1; k <= HOLD + 3; k++) begin
      new_data = (k == 100);  // must be ignored: link not ready yet
      data     = 8'h00;
      tick();
      if (ready === 1'b1 && first_ready == 0) first_ready = k;
      if (busy === 1'b0 && first_free == 0)   first_free  = k;
      if (tx !== 1'b1) bad++;
    end
    new_data = 1'b0;
    check("ready rise cycle", first_ready, 2 + HOLD);
    check("busy fall cycle", first_free, 3 + HOLD);
    check("tx idle during bring-up", bad, 0);

    // ---------------- table: back-to-back frames ----------------
    for (int i = 0; i < 6; i++)
      send_frame(vecs[i].data, vecs[i].frame, vecs[i].par, 1'b0,
                 $sformatf("vec%0d_%02h", i, vecs[i].data));

    // ---------------- avr_rx_busy during a frame ----------------
    fork
      send_frame(8'h5A, 10'b1_0101_1010_0, 1'b0, 1'b1, "abusy_5A");
      begin
        repeat (300) @(negedge clk);
        avr_rx_busy = 1'b1;
      end
    join
    repeat (20) tick();
    check("busy held by avr_rx_busy", busy, 1'b1);
    avr_rx_busy = 1'b0;
    new_data    = 1'b1;  // lands inside the release window and is dropped
    data        = 8'h00;
    lat         = 0;
    bad         = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      new_data = 1'b0;
      if (busy === 1'b0 && lat == 0) lat = i;
      if (tx !== 1'b1) bad++;
    end
    check("avr_rx_busy release latency", lat, 3);
    for (int i = 0; i < 200; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      tick();
    end
    check("dropped request sent nothing", bad, 0);

    // ---------------- cclk falls during a frame ----------------
    lat = 0;
    fork
      send_frame(8'hC3, 10'b1_1100_0011_0, 1'b0, 1'b1, "cclk_C3");
      begin
        repeat (400) @(negedge clk);
        cclk = 1'b0;
        for (int i = 1; i <= 10; i++) begin
          @(negedge clk);
          if (ready === 1'b0 && lat == 0) lat = i;
        end
      end
    join
    check("ready fall latency", lat, 3);
    new_data = 1'b1;
    data     = 8'h00;
    tick();
    new_data = 1'b0;
    bad      = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1) bad++;
      tick();
    end
    check("request ignored while not ready", bad, 0);

    cclk        = 1'b1;
    first_ready = 0;
    first_free  = 0;
    bad         = 0;
    for (int k = 1; k <= HOLD + 3; k++) begin
      tick();
      if (ready === 1'b1 && first_ready == 0) first_ready = k;
      if (busy === 1'b0 && first_free == 0)   first_free  = k;
      if (tx !== 1'b1) bad++;
    end
    check("ready re-rise cycle", first_ready, 2 + HOLD);
    check("busy re-fall cycle", first_free, 3 + HOLD);
    check("tx idle while re-arming", bad, 0);
    send_frame(8'h81, 10'b1_1000_0001_0, 1'b0, 1'b0, "recover_81");

    // ---------------- reset in the middle of a frame ----------------
    data     = 8'h00;
    new_data = 1'b1;
    tick();
    new_data = 1'b0;
    repeat (150) tick();
    check("tx low mid-frame", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("tx after async reset", tx, 1'b1);
    check("busy after async reset", busy, 1'b1);
    check("ready after async reset", ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("tx after reset release", tx, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
